// File: rtl/change_pkg.sv
// Shared types and constants for the change dispenser.
//   state_e  : dispenser FSM states
//   SEL_*    : coin_sel codes presented to the hopper
//   DEN_*_DEF: default coin values
package change_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPick,
    StPay,
    StDone
  } state_e;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_LO   = 2'b01;
  localparam logic [1:0] SEL_MID  = 2'b10;
  localparam logic [1:0] SEL_HI   = 2'b11;

  localparam int unsigned DEN_HI_DEF  = 5;
  localparam int unsigned DEN_MID_DEF = 2;
  localparam int unsigned DEN_LO_DEF  = 1;

endpackage

// File: rtl/coin_pick.sv
// Combinational greedy coin selector.
// Picks the highest denomination whose value fits in the remaining amount and
// whose inventory is non-empty.
//   remaining      : amount still to pay
//   inv_hi/mid/lo  : coins left per denomination
//   sel            : chosen coin code (SEL_NONE when nothing usable)
//   den            : value of the chosen coin (0 when none)
module coin_pick
  import change_pkg::*;
#(
  parameter int unsigned BAL_W   = 4,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned DEN_HI  = DEN_HI_DEF,
  parameter int unsigned DEN_MID = DEN_MID_DEF,
  parameter int unsigned DEN_LO  = DEN_LO_DEF
) (
  input  logic [BAL_W-1:0] remaining,
  input  logic [CNT_W-1:0] inv_hi,
  input  logic [CNT_W-1:0] inv_mid,
  input  logic [CNT_W-1:0] inv_lo,
  output logic [1:0]       sel,
  output logic [BAL_W-1:0] den
);

  localparam logic [BAL_W-1:0] DenHi  = BAL_W'(DEN_HI);
  localparam logic [BAL_W-1:0] DenMid = BAL_W'(DEN_MID);
  localparam logic [BAL_W-1:0] DenLo  = BAL_W'(DEN_LO);

  always_comb begin
    sel = SEL_NONE;
    den = '0;
    if ((inv_hi != '0) && (remaining >= DenHi)) begin
      sel = SEL_HI;
      den = DenHi;
    end else if ((inv_mid != '0) && (remaining >= DenMid)) begin
      sel = SEL_MID;
      den = DenMid;
    end else if ((inv_lo != '0) && (remaining >= DenLo)) begin
      sel = SEL_LO;
      den = DenLo;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: accepts a balance over req_valid/req_ready, pays it out
// greedily as HI/MID/LO coins through a hopper (coin_valid/coin_ack) and keeps
// per-denomination inventory counts.
//   clk, reset          : clock, asynchronous active-low reset
//   req_valid/ready     : request handshake, req_amount is the balance
//   refill              : restores all inventories to full (idle only)
//   coin_valid/sel/ack  : one-coin-at-a-time hopper handshake
//   done, short         : end-of-request pulse, exact change not possible
//   paid_amount         : total paid for the last request
//   inv_hi/mid/lo       : remaining coin counts
// Build option: define HOPPER_TIMEOUT_EN to treat a coin that is not acked
// within ACK_TIMEOUT cycles as jammed (its inventory is forced to 0).
module change_dispenser
  import change_pkg::*;
#(
`ifdef HOPPER_TIMEOUT_EN
  parameter int unsigned ACK_TIMEOUT = 15,
`endif
  parameter int unsigned BAL_W   = 4,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned DEN_HI  = DEN_HI_DEF,
  parameter int unsigned DEN_MID = DEN_MID_DEF,
  parameter int unsigned DEN_LO  = DEN_LO_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [BAL_W-1:0] req_amount,
  input  logic             refill,
  output logic             coin_valid,
  output logic [1:0]       coin_sel,
  input  logic             coin_ack,
  output logic             done,
  output logic             short,
  output logic [BAL_W-1:0] paid_amount,
  output logic [CNT_W-1:0] inv_hi,
  output logic [CNT_W-1:0] inv_mid,
  output logic [CNT_W-1:0] inv_lo
);

  localparam logic [CNT_W-1:0] InvFull = '1;

  state_e           state_q, state_d;
  logic [BAL_W-1:0] remaining_q, remaining_d;
  logic [BAL_W-1:0] den_q, den_d;
  logic [BAL_W-1:0] paid_q, paid_d;
  logic             short_q, short_d;
  logic             done_q, done_d;
  logic             coin_valid_q, coin_valid_d;
  logic [1:0]       coin_sel_q, coin_sel_d;
  logic [CNT_W-1:0] inv_hi_q, inv_hi_d;
  logic [CNT_W-1:0] inv_mid_q, inv_mid_d;
  logic [CNT_W-1:0] inv_lo_q, inv_lo_d;
  logic             req_ready_q;

  logic [1:0]       pick_sel;
  logic [BAL_W-1:0] pick_den;

`ifdef HOPPER_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(ACK_TIMEOUT + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;
`endif

  coin_pick #(
    .BAL_W  (BAL_W),
    .CNT_W  (CNT_W),
    .DEN_HI (DEN_HI),
    .DEN_MID(DEN_MID),
    .DEN_LO (DEN_LO)
  ) u_coin_pick (
    .remaining(remaining_q),
    .inv_hi   (inv_hi_q),
    .inv_mid  (inv_mid_q),
    .inv_lo   (inv_lo_q),
    .sel      (pick_sel),
    .den      (pick_den)
  );

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    den_d        = den_q;
    paid_d       = paid_q;
    short_d      = short_q;
    done_d       = 1'b0;
    coin_valid_d = coin_valid_q;
    coin_sel_d   = coin_sel_q;
    inv_hi_d     = inv_hi_q;
    inv_mid_d    = inv_mid_q;
    inv_lo_d     = inv_lo_q;
`ifdef HOPPER_TIMEOUT_EN
    tmo_d        = tmo_q;
`endif
    unique case (state_q)
      StIdle: begin
        // Refill lands before the following PICK, so an accept in the same
        // cycle already sees full inventory.
        if (refill) begin
          inv_hi_d  = InvFull;
          inv_mid_d = InvFull;
          inv_lo_d  = InvFull;
        end
        if (req_valid && req_ready_q) begin
          remaining_d = req_amount;
          paid_d      = '0;
          short_d     = 1'b0;
          state_d     = StPick;
        end
      end
      StPick: begin
`ifdef HOPPER_TIMEOUT_EN
        tmo_d = '0;
`endif
        if (pick_sel != SEL_NONE) begin
          coin_valid_d = 1'b1;
          coin_sel_d   = pick_sel;
          den_d        = pick_den;
          state_d      = StPay;
        end else begin
          done_d  = 1'b1;
          short_d = (remaining_q != '0);
          state_d = StDone;
        end
      end
      StPay: begin
        if (coin_ack) begin
          // den <= remaining and inventory > 0 were guaranteed by the picker.
          remaining_d = remaining_q - den_q;
          paid_d      = paid_q + den_q;
          case (coin_sel_q)
            SEL_HI:  inv_hi_d  = inv_hi_q - CNT_W'(1);
            SEL_MID: inv_mid_d = inv_mid_q - CNT_W'(1);
            SEL_LO:  inv_lo_d  = inv_lo_q - CNT_W'(1);
            default: ;
          endcase
          coin_valid_d = 1'b0;
          coin_sel_d   = SEL_NONE;
          state_d      = StPick;
        end
`ifdef HOPPER_TIMEOUT_EN
        else if (tmo_q == TmoW'(ACK_TIMEOUT - 1)) begin
          // Jammed denomination: mark it empty so the picker skips it.
          case (coin_sel_q)
            SEL_HI:  inv_hi_d  = '0;
            SEL_MID: inv_mid_d = '0;
            SEL_LO:  inv_lo_d  = '0;
            default: ;
          endcase
          coin_valid_d = 1'b0;
          coin_sel_d   = SEL_NONE;
          state_d      = StPick;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
`endif
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      remaining_q  <= '0;
      den_q        <= '0;
      paid_q       <= '0;
      short_q      <= 1'b0;
      done_q       <= 1'b0;
      coin_valid_q <= 1'b0;
      coin_sel_q   <= SEL_NONE;
      inv_hi_q     <= InvFull;
      inv_mid_q    <= InvFull;
      inv_lo_q     <= InvFull;
      req_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      den_q        <= den_d;
      paid_q       <= paid_d;
      short_q      <= short_d;
      done_q       <= done_d;
      coin_valid_q <= coin_valid_d;
      coin_sel_q   <= coin_sel_d;
      inv_hi_q     <= inv_hi_d;
      inv_mid_q    <= inv_mid_d;
      inv_lo_q     <= inv_lo_d;
      req_ready_q  <= (state_d == StIdle);
    end
  end

`ifdef HOPPER_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  assign req_ready   = req_ready_q;
  assign coin_valid  = coin_valid_q;
  assign coin_sel    = coin_sel_q;
  assign done        = done_q;
  assign short       = short_q;
  assign paid_amount = paid_q;
  assign inv_hi      = inv_hi_q;
  assign inv_mid     = inv_mid_q;
  assign inv_lo      = inv_lo_q;

endmodule
